// File: rtl/adder_err_pkg.sv
// Shared types, default sizes and helpers for the approximate-adder error sweep.
package adder_err_pkg;

  localparam int unsigned DefNIn  = 4;
  localparam int unsigned DefNOut = 3;
  localparam int unsigned DefEt   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } sweep_state_e;

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/adder_exact_ref.sv
// Combinational exact reference adder: two W-bit operands to a (W+1)-bit sum.
module adder_exact_ref #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W:0]   o_sum
);

  assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/adder_err_sweep.sv
// Exhaustive error sweep of an approximate adder against an exact reference.
// Optional mean-error accumulator (o_sum_err) is built when ADDER_ERR_SUM_EN is defined.
module adder_err_sweep
  import adder_err_pkg::*;
#(
  parameter int unsigned N_IN   = DefNIn,
  parameter int unsigned N_OUT  = DefNOut,
  parameter int unsigned ET     = DefEt,
  parameter int unsigned SETTLE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [N_IN-1:0]  o_dut_in,
  input  logic [N_OUT-1:0] i_dut_out,
  output logic [N_OUT-1:0] o_max_err,
  output logic [N_IN-1:0]  o_worst_vec,
  output logic [N_IN:0]    o_viol_cnt,
`ifdef ADDER_ERR_SUM_EN
  output logic [N_IN+N_OUT-1:0] o_sum_err,
`endif
  output logic             o_pass
);

  localparam int unsigned HalfW = N_IN / 2;
  localparam int unsigned CntW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE - 1);
  localparam logic [N_IN:0]   LastVec = {1'b0, {N_IN{1'b1}}};

  sweep_state_e r_state, w_state_d;

  logic [N_IN:0]    r_vec;
  logic [CntW-1:0]  r_cnt;
  logic [N_OUT-1:0] r_err;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [N_OUT-1:0] r_max_err;
  logic [N_IN-1:0]  r_worst_vec;
  logic [N_IN:0]    r_viol_cnt;

  logic [N_OUT-1:0] w_exact;
  logic [N_OUT-1:0] w_err;
  logic             w_last;
  logic             w_accept;
  logic             w_capture;
  logic             w_sample;
  logic             w_finish;

  adder_exact_ref #(
    .W(HalfW)
  ) u_exact (
    .i_a  (r_vec[HalfW-1:0]),
    .i_b  (r_vec[N_IN-1:HalfW]),
    .o_sum(w_exact)
  );

  assign w_err  = N_OUT'(abs_diff(32'(i_dut_out), 32'(w_exact)));
  assign w_last = (r_vec == LastVec);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_sample  = 1'b0;
    w_finish  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_accept  = 1'b1;
          w_state_d = StSettle;
        end
      end
      StSettle: begin
        if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_state_d = StSample;
        end
      end
      StSample: begin
        w_sample  = 1'b1;
        w_state_d = w_last ? StDone : StSettle;
      end
      StDone: begin
        w_finish  = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // dut_out is captured on the edge that ends the settle window, SETTLE cycles after vec moved.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vec       <= '0;
      r_cnt       <= '0;
      r_err       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_max_err   <= '0;
      r_worst_vec <= '0;
      r_viol_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_vec       <= '0;
        r_cnt       <= CntLoad;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_pass      <= 1'b0;
        r_max_err   <= '0;
        r_worst_vec <= '0;
        r_viol_cnt  <= '0;
      end
      if (r_state == StSettle) begin
        if (w_capture) begin
          r_err <= w_err;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
      if (w_sample) begin
        if (r_err > r_max_err) begin
          r_max_err   <= r_err;
          r_worst_vec <= r_vec[N_IN-1:0];
        end
        if (32'(r_err) > ET) begin
          r_viol_cnt <= r_viol_cnt + 1'b1;
        end
        if (!w_last) begin
          r_vec <= r_vec + 1'b1;
          r_cnt <= CntLoad;
        end
      end
      if (w_finish) begin
        r_pass <= (32'(r_max_err) <= ET);
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

`ifdef ADDER_ERR_SUM_EN
  logic [N_IN+N_OUT-1:0] r_sum_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum_err <= '0;
    end else if (w_accept) begin
      r_sum_err <= '0;
    end else if (w_sample) begin
      r_sum_err <= r_sum_err + (N_IN + N_OUT)'(r_err);
    end
  end

  assign o_sum_err = r_sum_err;
`endif

  assign o_dut_in    = r_vec[N_IN-1:0];
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_max_err   = r_max_err;
  assign o_worst_vec = r_worst_vec;
  assign o_viol_cnt  = r_viol_cnt;

endmodule

// File: tb/tb_adder_err_sweep.sv
// Directed bench for adder_err_sweep: stubbed approximate adders, timing, restart and reset.
module tb_adder_err_sweep;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start2;
  always #5 clk = ~clk;

  logic       busy, done, pass;
  logic [3:0] dut_in, worst_vec;
  logic [2:0] dut_out, max_err;
  logic [4:0] viol_cnt;

  logic       busy2, done2, pass2;
  logic [3:0] dut_in2, worst_vec2;
  logic [2:0] dut_out2, max_err2;
  logic [4:0] viol_cnt2;

`ifdef ADDER_ERR_SUM_EN
  logic [6:0] sum_err, sum_err2;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int mode     = 0;

  logic [2:0] d1, d2, e1, e2;

  function automatic logic [2:0] ref_sum(input logic [3:0] v);
    return {1'b0, v[1:0]} + {1'b0, v[3:2]};
  endfunction

  // Stub modes: 0 exact, 1 stuck at zero, 2 exact+1 at 4'b0101, 3 two-flop delayed exact
  always_comb begin
    dut_out = ref_sum(dut_in);
    case (mode)
      1: dut_out = 3'd0;
      2: if (dut_in == 4'b0101) dut_out = ref_sum(dut_in) + 3'd1;
      3: dut_out = d2;
      default: ;
    endcase
  end

  always @(posedge clk) begin
    d1 <= ref_sum(dut_in);
    d2 <= d1;
    e1 <= ref_sum(dut_in2);
    e2 <= e1;
  end
  assign dut_out2 = e2;

  adder_err_sweep #(.N_IN(4), .N_OUT(3), .ET(4), .SETTLE(1)) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_dut_in   (dut_in),
    .i_dut_out  (dut_out),
    .o_max_err  (max_err),
    .o_worst_vec(worst_vec),
    .o_viol_cnt (viol_cnt),
`ifdef ADDER_ERR_SUM_EN
    .o_sum_err  (sum_err),
`endif
    .o_pass     (pass)
  );

  adder_err_sweep #(.N_IN(4), .N_OUT(3), .ET(4), .SETTLE(3)) u_dut_slow (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start2),
    .o_busy     (busy2),
    .o_done     (done2),
    .o_dut_in   (dut_in2),
    .i_dut_out  (dut_out2),
    .o_max_err  (max_err2),
    .o_worst_vec(worst_vec2),
    .o_viol_cnt (viol_cnt2),
`ifdef ADDER_ERR_SUM_EN
    .o_sum_err  (sum_err2),
`endif
    .o_pass     (pass2)
  );

  // Pulses start, then counts edges after the start edge until done; optional re-start mid-sweep.
  task automatic run_sweep(input int restart_at, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL busy_after_start busy=%b done=%b want 1/0", busy, done);
    else n_pass++;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (cyc == restart_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, done, pass, dut_in, max_err, worst_vec, viol_cnt} !== 17'd0)
      $display("FAIL reset_state busy=%b done=%b pass=%b in=%h max=%0d worst=%h viol=%0d want all 0",
               busy, done, pass, dut_in, max_err, worst_vec, viol_cnt);
    else n_pass++;
  endtask

  task automatic test_exact();
    int cyc;
    mode = 0;
    run_sweep(-1, cyc);
    n_checks++;
    if (cyc !== 33) $display("FAIL exact_latency got %0d want 33", cyc); else n_pass++;
    n_checks++;
    if ({max_err, worst_vec, viol_cnt, pass, busy} !== {3'd0, 4'd0, 5'd0, 1'b1, 1'b0})
      $display("FAIL exact_results max=%0d worst=%h viol=%0d pass=%b busy=%b want 0/0/0/1/0",
               max_err, worst_vec, viol_cnt, pass, busy);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b1) $display("FAIL exact_hold done=%b pass=%b want 1/1", done, pass);
    else n_pass++;
  endtask

  task automatic test_zero_out(input int restart_at, input string tag);
    int cyc;
    mode = 1;
    run_sweep(restart_at, cyc);
    n_checks++;
    if (cyc !== 33) $display("FAIL %s_latency got %0d want 33", tag, cyc); else n_pass++;
    n_checks++;
    if (max_err !== 3'd6) $display("FAIL %s_max_err got %0d want 6", tag, max_err); else n_pass++;
    n_checks++;
    if (worst_vec !== 4'b1111) $display("FAIL %s_worst got %b want 1111", tag, worst_vec);
    else n_pass++;
    n_checks++;
    if (viol_cnt !== 5'd3) $display("FAIL %s_viol got %0d want 3", tag, viol_cnt); else n_pass++;
    n_checks++;
    if (pass !== 1'b0) $display("FAIL %s_pass got %b want 0", tag, pass); else n_pass++;
`ifdef ADDER_ERR_SUM_EN
    n_checks++;
    if (sum_err !== 7'd48) $display("FAIL %s_sum_err got %0d want 48", tag, sum_err); else n_pass++;
`endif
  endtask

  task automatic test_single_err();
    int cyc;
    mode = 2;
    run_sweep(-1, cyc);
    n_checks++;
    if ({max_err, worst_vec, viol_cnt, pass} !== {3'd1, 4'b0101, 5'd0, 1'b1})
      $display("FAIL single_err max=%0d worst=%b viol=%0d pass=%b want 1/0101/0/1",
               max_err, worst_vec, viol_cnt, pass);
    else n_pass++;
`ifdef ADDER_ERR_SUM_EN
    n_checks++;
    if (sum_err !== 7'd1) $display("FAIL single_sum_err got %0d want 1", sum_err); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, pass, dut_in, max_err, worst_vec, viol_cnt} !== 17'd0)
      $display("FAIL reset_mid busy=%b done=%b pass=%b in=%h max=%0d worst=%h viol=%0d want all 0",
               busy, done, pass, dut_in, max_err, worst_vec, viol_cnt);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL reset_idle busy/done seen high %0d times want 0", bad); else n_pass++;
  endtask

  task automatic test_latency();
    int cyc;
    mode = 3;
    run_sweep(-1, cyc);
    n_checks++;
    if (!(max_err > 3'd0)) $display("FAIL short_settle_max got %0d want >0", max_err); else n_pass++;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc !== 65) $display("FAIL long_settle_latency got %0d want 65", cyc); else n_pass++;
    n_checks++;
    if ({max_err2, viol_cnt2, pass2} !== {3'd0, 5'd0, 1'b1})
      $display("FAIL long_settle_results max=%0d viol=%0d pass=%b want 0/0/1",
               max_err2, viol_cnt2, pass2);
    else n_pass++;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_exact();
    test_zero_out(-1, "zero");
    test_single_err();
    test_zero_out(9, "restart_ignored");
    test_reset_mid();
    test_latency();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
